// File: rtl/sd_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : sd_pkg                                                        |
// | Description : sd_interface register map and DMA sequencer state encoding.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

package sd_pkg;

   localparam logic [7:0] REG_LBA0 = 8'h00;
   localparam logic [7:0] REG_LBA1 = 8'h01;
   localparam logic [7:0] REG_LBA2 = 8'h02;
   localparam logic [7:0] REG_LBA3 = 8'h03;
   localparam logic [7:0] REG_BUSY = 8'h04;
   localparam logic [7:0] REG_RD   = 8'h05;
   localparam logic [7:0] REG_WR   = 8'h06;
   localparam logic [7:0] REG_PAGE = 8'h07;
   localparam logic [7:0] REG_STAT = 8'h08;
   localparam logic [7:0] BUF_BASE = 8'h80;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PRE_POLL = 4'd1,
      ST_SET_ADDR = 4'd2,
      ST_START    = 4'd3,
      ST_GUARD    = 4'd4,
      ST_POLL     = 4'd5,
      ST_SET_PAGE = 4'd6,
      ST_COPY     = 4'd7,
      ST_NEXT     = 4'd8,
      ST_DONE     = 4'd9
   } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/sd_bus_mux.sv
// +-----------------------------------------------------------------------------+
// | Module      : sd_bus_mux                                                    |
// | Description : Selects CPU or sequencer onto the sd register bus.            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sd_bus_mux (
   input  logic       fsm_sel_i,
   input  logic       busy_i,
   input  logic       cpu_cs_i,
   input  logic       cpu_rw_n_i,
   input  logic [7:0] cpu_addr_i,
   input  logic [7:0] cpu_wdata_i,
   output logic [7:0] cpu_rdata_o,
   input  logic       fsm_cs_i,
   input  logic       fsm_rw_n_i,
   input  logic [7:0] fsm_addr_i,
   input  logic [7:0] fsm_wdata_i,
   output logic       sd_cs_o,
   output logic       sd_rw_n_o,
   output logic [7:0] sd_addr_o,
   output logic [7:0] sd_wdata_o,
   input  logic [7:0] sd_rdata_i
);

   // CPU chip select is dropped entirely while the sequencer owns the bus
   always_comb begin
      sd_cs_o     = fsm_sel_i ? fsm_cs_i    : cpu_cs_i;
      sd_rw_n_o   = fsm_sel_i ? fsm_rw_n_i  : cpu_rw_n_i;
      sd_addr_o   = fsm_sel_i ? fsm_addr_i  : cpu_addr_i;
      sd_wdata_o  = fsm_sel_i ? fsm_wdata_i : cpu_wdata_i;
      cpu_rdata_o = busy_i    ? 8'hFF       : sd_rdata_i;
   end

endmodule

`default_nettype wire

// File: rtl/sd_dma_ctrl.sv
// +-----------------------------------------------------------------------------+
// | Module      : sd_dma_ctrl                                                   |
// | Description : Copies N 512-byte SD sectors into byte-wide memory.           |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sd_dma_ctrl
   import sd_pkg::*;
#(
   parameter int MEM_AW       = 16,
   parameter int GUARD_CYCLES = 4,
   parameter int TIMEOUT      = 1000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [31:0]       sector_i,
   input  logic [7:0]        count_i,
   input  logic [MEM_AW-1:0] dest_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              cpu_cs_i,
   input  logic              cpu_rw_n_i,
   input  logic [7:0]        cpu_addr_i,
   input  logic [7:0]        cpu_wdata_i,
   output logic [7:0]        cpu_rdata_o,
   output logic              sd_cs_o,
   output logic              sd_rw_n_o,
   output logic [7:0]        sd_addr_o,
   output logic [7:0]        sd_wdata_o,
   input  logic [7:0]        sd_rdata_i,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o
);

   localparam logic [23:0] c_tmo_last   = 24'(TIMEOUT - 1);
   localparam logic [23:0] c_guard_last = 24'(GUARD_CYCLES - 1);

   dma_state_e        r_state, w_next;
   logic [31:0]       r_sector;
   logic [7:0]        r_count;
   logic [MEM_AW-1:0] r_dest;
   logic [1:0]        r_page;
   logic [6:0]        r_idx;
   logic [23:0]       r_cnt;
   logic              r_poll_vld;
   logic              r_busy;
   logic              r_err;
   logic              r_we;
   logic [MEM_AW-1:0] r_maddr;

   logic              w_fsm_cs;
   logic              w_fsm_rw_n;
   logic [7:0]        w_fsm_addr;
   logic [7:0]        w_fsm_wdata;
   logic              w_poll_clr;
   logic              w_tmo_hit;
   logic              w_is_poll;

   // Read data is valid one cycle after a busy-register read was issued
   assign w_poll_clr = r_poll_vld & ~sd_rdata_i[0];
   assign w_tmo_hit  = (r_cnt == c_tmo_last);
   assign w_is_poll  = (r_state == ST_PRE_POLL) || (r_state == ST_POLL);

   always_comb begin
      w_next      = r_state;
      w_fsm_cs    = 1'b0;
      w_fsm_rw_n  = 1'b1;
      w_fsm_addr  = 8'h00;
      w_fsm_wdata = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (start_i && !r_busy)
               w_next = (count_i == 8'd0) ? ST_DONE : ST_PRE_POLL;
         end
         ST_PRE_POLL, ST_POLL: begin
            if (w_poll_clr)
               w_next = (r_state == ST_PRE_POLL) ? ST_SET_ADDR : ST_SET_PAGE;
            else if (w_tmo_hit)
               w_next = ST_DONE;
            else begin
               w_fsm_cs   = 1'b1;
               w_fsm_addr = REG_BUSY;
            end
         end
         ST_SET_ADDR: begin
            w_fsm_cs   = 1'b1;
            w_fsm_rw_n = 1'b0;
            w_fsm_addr = REG_LBA0 + {6'd0, r_cnt[1:0]};
            case (r_cnt[1:0])
               2'd0:    w_fsm_wdata = r_sector[7:0];
               2'd1:    w_fsm_wdata = r_sector[15:8];
               2'd2:    w_fsm_wdata = r_sector[23:16];
               default: w_fsm_wdata = r_sector[31:24];
            endcase
            if (r_cnt[1:0] == 2'd3)
               w_next = ST_START;
         end
         ST_START: begin
            w_fsm_cs   = 1'b1;
            w_fsm_rw_n = 1'b0;
            w_fsm_addr = REG_RD;
            w_next     = ST_GUARD;
         end
         ST_GUARD: begin
            if (r_cnt >= c_guard_last)
               w_next = ST_POLL;
         end
         ST_SET_PAGE: begin
            // second cycle is an idle settle after the page write
            if (r_cnt == 24'd0) begin
               w_fsm_cs    = 1'b1;
               w_fsm_rw_n  = 1'b0;
               w_fsm_addr  = REG_PAGE;
               w_fsm_wdata = {6'd0, r_page};
            end else begin
               w_next = ST_COPY;
            end
         end
         ST_COPY: begin
            w_fsm_cs   = 1'b1;
            w_fsm_addr = BUF_BASE | {1'b0, r_idx};
            if (r_idx == 7'd127)
               w_next = ST_NEXT;
         end
         ST_NEXT: begin
            if (r_page != 2'd3)
               w_next = ST_SET_PAGE;
            else if (r_count == 8'd1)
               w_next = ST_DONE;
            else
               w_next = ST_SET_ADDR;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_sector   <= 32'd0;
         r_count    <= 8'd0;
         r_dest     <= '0;
         r_page     <= 2'd0;
         r_idx      <= 7'd0;
         r_cnt      <= 24'd0;
         r_poll_vld <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_we       <= 1'b0;
         r_maddr    <= '0;
      end else begin
         r_state    <= w_next;
         r_busy     <= (w_next != ST_IDLE);
         r_cnt      <= (w_next != r_state) ? 24'd0 : r_cnt + 24'd1;
         r_poll_vld <= w_is_poll & w_fsm_cs;
         r_idx      <= (r_state == ST_COPY) ? r_idx + 7'd1 : 7'd0;
         r_we       <= (r_state == ST_COPY);
         r_maddr    <= r_dest + MEM_AW'({r_page, r_idx});

         if (r_state == ST_IDLE && start_i && !r_busy) begin
            r_sector <= sector_i;
            r_count  <= count_i;
            r_dest   <= dest_i;
            r_err    <= 1'b0;
         end

         if (w_is_poll && !w_poll_clr && w_tmo_hit)
            r_err <= 1'b1;

         if (r_state == ST_POLL && w_poll_clr)
            r_page <= 2'd0;

         if (r_state == ST_NEXT) begin
            if (r_page != 2'd3) begin
               r_page <= r_page + 2'd1;
            end else begin
               r_sector <= r_sector + 32'd1;
               r_dest   <= r_dest + MEM_AW'(512);
               r_count  <= r_count - 8'd1;
            end
         end
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = (r_state == ST_DONE);
   assign err_o       = r_err;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_maddr;
   assign mem_wdata_o = sd_rdata_i;

   sd_bus_mux u_bus_mux (
      .fsm_sel_i   (r_state != ST_IDLE),
      .busy_i      (r_busy),
      .cpu_cs_i    (cpu_cs_i),
      .cpu_rw_n_i  (cpu_rw_n_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .fsm_cs_i    (w_fsm_cs),
      .fsm_rw_n_i  (w_fsm_rw_n),
      .fsm_addr_i  (w_fsm_addr),
      .fsm_wdata_i (w_fsm_wdata),
      .sd_cs_o     (sd_cs_o),
      .sd_rw_n_o   (sd_rw_n_o),
      .sd_addr_o   (sd_addr_o),
      .sd_wdata_o  (sd_wdata_o),
      .sd_rdata_i  (sd_rdata_i)
   );

endmodule

`default_nettype wire

// File: tb/tb_sd_dma_ctrl.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_sd_dma_ctrl                                                |
// | Description : Directed bench for sd_dma_ctrl with a behavioural SD model.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_sd_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] sector_i = 32'd0;
   logic [7:0]  count_i = 8'd0;
   logic [15:0] dest_i = 16'd0;
   logic        busy_o, done_o, err_o;
   logic        cpu_cs_i = 1'b0, cpu_rw_n_i = 1'b1;
   logic [7:0]  cpu_addr_i = 8'd0, cpu_wdata_i = 8'd0;
   logic [7:0]  cpu_rdata_o;
   logic        sd_cs_o, sd_rw_n_o;
   logic [7:0]  sd_addr_o, sd_wdata_o;
   logic [7:0]  sd_rdata_i = 8'd0;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;

   sd_dma_ctrl #(.MEM_AW(16), .GUARD_CYCLES(4), .TIMEOUT(1000)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sector_i(sector_i),
      .count_i(count_i), .dest_i(dest_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .cpu_cs_i(cpu_cs_i), .cpu_rw_n_i(cpu_rw_n_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
      .sd_cs_o(sd_cs_o), .sd_rw_n_o(sd_rw_n_o), .sd_addr_o(sd_addr_o),
      .sd_wdata_o(sd_wdata_o), .sd_rdata_i(sd_rdata_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [31:0] lba, input logic [8:0] off);
      logic [8:0] t;
      t   = off * 9'd3;
      pat = lba[7:0] ^ lba[15:8] ^ lba[31:24] ^ t[7:0] ^ {7'd0, off[8]} ^ 8'h5A;
   endfunction

   // ---------------- behavioural sd_interface ----------------
   logic [7:0]  m_lba [4];
   logic [31:0] m_cur = 32'd0;
   logic [1:0]  m_page = 2'd0;
   int          m_busy_cnt = 0, m_dly = 0, cyc = 0, hold_until = 0;
   logic        m_stuck = 1'b0;
   localparam int K = 50;
   wire         m_busy = (m_busy_cnt != 0) || m_stuck || (cyc < hold_until);

   initial for (int i = 0; i < 4; i++) m_lba[i] = 8'h00;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
      if (m_dly != 0) begin
         m_dly <= m_dly - 1;
         if (m_dly == 1) m_busy_cnt <= K;
      end
      if (sd_cs_o && !sd_rw_n_o) begin
         if (sd_addr_o < 8'h04) m_lba[sd_addr_o[1:0]] <= sd_wdata_o;
         if (sd_addr_o == 8'h05) begin
            m_dly <= 2;
            m_cur <= {m_lba[3], m_lba[2], m_lba[1], m_lba[0]};
         end
         if (sd_addr_o == 8'h07) m_page <= sd_wdata_o[1:0];
      end
      if (sd_cs_o && sd_rw_n_o) begin
         if (sd_addr_o == 8'h04)  sd_rdata_i <= {7'd0, m_busy};
         else if (sd_addr_o[7])   sd_rdata_i <= pat(m_cur, {m_page, sd_addr_o[6:0]});
         else                     sd_rdata_i <= 8'h00;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0] job_sector = 32'd0;
   logic [15:0] job_dest = 16'd0;
   int wr_base = 0, page_base = 0;
   int wr_cnt = 0, wr_bad = 0, acc_cnt = 0, wr6_cnt = 0, page_cnt = 0, page_bad = 0;
   int done_cnt = 0, start_cnt = 0, start_cyc = 0;
   logic        done_err = 1'b0;
   logic [15:0] last_addr = 16'd0;
   logic [31:0] lba_log [16];

   always @(negedge clk) begin
      int n;
      logic [31:0] e_lba;
      logic [15:0] e_addr;
      if (mem_we_o) begin
         n      = wr_cnt - wr_base;
         e_lba  = job_sector + 32'(n / 512);
         e_addr = job_dest + 16'(n);
         if (mem_addr_o !== e_addr || mem_wdata_o !== pat(e_lba, 9'(n % 512)))
            wr_bad <= wr_bad + 1;
         wr_cnt    <= wr_cnt + 1;
         last_addr <= mem_addr_o;
      end
      if (sd_cs_o) acc_cnt <= acc_cnt + 1;
      if (sd_cs_o && !sd_rw_n_o && sd_addr_o == 8'h06) wr6_cnt <= wr6_cnt + 1;
      if (sd_cs_o && !sd_rw_n_o && sd_addr_o == 8'h07) begin
         if (sd_wdata_o != 8'((page_cnt - page_base) % 4)) page_bad <= page_bad + 1;
         page_cnt <= page_cnt + 1;
      end
      if (sd_cs_o && !sd_rw_n_o && sd_addr_o == 8'h05) begin
         lba_log[start_cnt % 16] <= {m_lba[3], m_lba[2], m_lba[1], m_lba[0]};
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
      if (done_o) begin
         done_cnt <= done_cnt + 1;
         done_err <= err_o;
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int b_wr, b_bad, b_acc, b_done, b_start, b_page, b_wr6;

   task automatic snap();
      b_wr = wr_cnt; b_bad = wr_bad; b_acc = acc_cnt; b_done = done_cnt;
      b_start = start_cnt; b_page = page_cnt; b_wr6 = wr6_cnt;
   endtask

   // Launch a job; returns cycles from start drive to done being seen (-1 on expiry)
   task automatic run_job(input logic [31:0] sec, input logic [7:0] cnt, input logic [15:0] dst,
                          input int limit, output int lat, output logic busy_after);
      job_sector = sec; job_dest = dst;
      wr_base = wr_cnt; page_base = page_cnt;
      snap();
      start_i = 1'b1; sector_i = sec; count_i = cnt; dest_i = dst;
      step();
      start_i = 1'b0;
      busy_after = busy_o;
      lat = 1;
      while (done_cnt == b_done && lat < limit) begin
         step();
         lat++;
      end
      if (done_cnt == b_done) lat = -1;
   endtask

   int   lat;
   logic bz;

   initial begin
      repeat (3) step();
      rst_i = 1'b0;
      step();
      check_val("reset_outputs", {busy_o, done_o, err_o, mem_we_o}, 4'b0000);

      // 1: single sector
      run_job(32'h0000_0010, 8'd1, 16'h2000, 5000, lat, bz);
      check_val("t1_busy_rises", bz, 1);
      check_val("t1_done_seen", lat > 0, 1);
      repeat (3) step();
      check_val("t1_lba_regs", {m_lba[3], m_lba[2], m_lba[1], m_lba[0]}, 32'h0000_0010);
      check_val("t1_starts", start_cnt - b_start, 1);
      check_val("t1_writes", wr_cnt - b_wr, 512);
      check_val("t1_data_bad", wr_bad - b_bad, 0);
      check_val("t1_last_addr", last_addr, 16'h21FF);
      check_val("t1_done_cnt", done_cnt - b_done, 1);
      check_val("t1_err", {done_err, err_o, busy_o}, 3'b000);

      // 2: three sectors, LBA and destination wrap
      run_job(32'hFFFF_FFFF, 8'd3, 16'hFF00, 8000, lat, bz);
      check_val("t2_done_seen", lat > 0, 1);
      repeat (3) step();
      check_val("t2_starts", start_cnt - b_start, 3);
      check_val("t2_lba0", lba_log[b_start % 16], 32'hFFFF_FFFF);
      check_val("t2_lba1", lba_log[(b_start + 1) % 16], 32'h0000_0000);
      check_val("t2_lba2", lba_log[(b_start + 2) % 16], 32'h0000_0001);
      check_val("t2_writes", wr_cnt - b_wr, 1536);
      check_val("t2_data_bad", wr_bad - b_bad, 0);
      check_val("t2_last_addr", last_addr, 16'h04FF);
      check_val("t2_page_writes", page_cnt - b_page, 12);
      check_val("t2_page_seq_bad", page_bad, 0);

      // 3: empty job
      run_job(32'h0000_0100, 8'd0, 16'h1000, 20, lat, bz);
      check_val("t3_done_latency", lat, 2);
      check_val("t3_busy_low_after", busy_o, 0);
      step();
      check_val("t3_sd_accesses", acc_cnt - b_acc, 0);
      check_val("t3_writes", wr_cnt - b_wr, 0);

      // 4: stuck busy -> timeout
      m_stuck = 1'b1;
      run_job(32'h0000_0005, 8'd1, 16'h3000, 3000, lat, bz);
      check_val("t4_timeout_window", (lat >= 995 && lat <= 1010), 1);
      check_val("t4_done_with_err", done_err, 1);
      b_acc = acc_cnt;
      repeat (50) step();
      check_val("t4_no_sd_after", acc_cnt - b_acc, 0);
      check_val("t4_err_held", err_o, 1);
      m_stuck = 1'b0;
      start_i = 1'b1; count_i = 8'd0;
      step();
      start_i = 1'b0;
      check_val("t4_err_cleared", err_o, 0);
      repeat (3) step();

      // 5: CPU passthrough while idle, blocked during a job
      cpu_cs_i = 1'b1; cpu_rw_n_i = 1'b0; cpu_addr_i = 8'h00; cpu_wdata_i = 8'hA5;
      #1;
      check_val("t5_pass_write", {sd_cs_o, sd_rw_n_o, sd_addr_o, sd_wdata_o}, {2'b10, 8'h00, 8'hA5});
      step();
      cpu_cs_i = 1'b0;
      step();
      check_val("t5_reg0_written", m_lba[0], 8'hA5);
      m_stuck = 1'b1;
      cpu_cs_i = 1'b1; cpu_rw_n_i = 1'b1; cpu_addr_i = 8'h04;
      step();
      cpu_cs_i = 1'b0;
      check_val("t5_pass_read", cpu_rdata_o, 8'h01);
      m_stuck = 1'b0;
      step();
      job_sector = 32'h0000_0020; job_dest = 16'h4000;
      wr_base = wr_cnt; page_base = page_cnt;
      snap();
      start_i = 1'b1; sector_i = 32'h20; count_i = 8'd1; dest_i = 16'h4000;
      step();
      start_i = 1'b0;
      repeat (5) step();
      cpu_cs_i = 1'b1; cpu_rw_n_i = 1'b0; cpu_addr_i = 8'h06; cpu_wdata_i = 8'h3C;
      repeat (10) step();
      check_val("t5_rdata_masked", cpu_rdata_o, 8'hFF);
      repeat (10) step();
      cpu_cs_i = 1'b0;
      lat = 0;
      while (done_cnt == b_done && lat < 5000) begin step(); lat++; end
      check_val("t5_done_seen", done_cnt - b_done, 1);
      check_val("t5_cpu_blocked", wr6_cnt - b_wr6, 0);
      check_val("t5_writes", wr_cnt - b_wr, 512);
      check_val("t5_data_bad", wr_bad - b_bad, 0);
      repeat (3) step();

      // 6: reset mid-copy, then a job that must wait out an in-flight op
      job_sector = 32'h0000_0040; job_dest = 16'h5000;
      wr_base = wr_cnt; page_base = page_cnt;
      snap();
      start_i = 1'b1; sector_i = 32'h40; count_i = 8'd1; dest_i = 16'h5000;
      step();
      start_i = 1'b0;
      lat = 0;
      while (wr_cnt - b_wr < 200 && lat < 5000) begin step(); lat++; end
      check_val("t6_reached_byte200", wr_cnt - b_wr >= 200, 1);
      rst_i = 1'b1;
      step();
      check_val("t6_reset_busy_we", {busy_o, mem_we_o}, 2'b00);
      rst_i = 1'b0;
      repeat (20) step();
      check_val("t6_no_done", done_cnt - b_done, 0);
      hold_until = cyc + 300;
      run_job(32'h0000_0041, 8'd1, 16'h6000, 5000, lat, bz);
      check_val("t6_done_seen", lat > 0, 1);
      repeat (3) step();
      check_val("t6_waited_pre_poll", start_cyc >= hold_until, 1);
      check_val("t6_writes", wr_cnt - b_wr, 512);
      check_val("t6_data_bad", wr_bad - b_bad, 0);
      check_val("t6_err", done_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
